// File: rtl/vscale_mem_arbiter.sv
// Shares one memory request/response channel between the vscale fetch and data ports.
// Optional: define VSCALE_MEM_ARB_ALIGN_CHECK_EN to complete misaligned data accesses locally with an error.
module vscale_mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  imem_req,
   input  logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  imem_wait,
   output logic                  imem_badmem_e,
   input  logic                  dmem_en,
   input  logic                  dmem_wen,
   input  logic [2:0]            dmem_size,
   input  logic [ADDR_WIDTH-1:0] dmem_addr,
   input  logic [DATA_WIDTH-1:0] dmem_wdata,
   output logic [DATA_WIDTH-1:0] dmem_rdata,
   output logic                  dmem_wait,
   output logic                  dmem_badmem_e,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   output logic                  mem_req_wen,
   output logic [2:0]            mem_req_size,
   output logic [DATA_WIDTH-1:0] mem_req_wdata,
   input  logic                  mem_resp_valid,
   input  logic [DATA_WIDTH-1:0] mem_resp_data,
   input  logic                  mem_resp_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_RESP,
      S_AERR
   } state_t;

   state_t                r_state;
   logic                  r_owner;
   logic                  r_req_valid;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_wen;
   logic [2:0]            r_size;
   logic [DATA_WIDTH-1:0] r_wdata;

   logic w_misalign;
   logic w_done;
   logic w_aerr;
   logic w_done_i;
   logic w_done_d;

`ifdef VSCALE_MEM_ARB_ALIGN_CHECK_EN
   assign w_misalign = ((dmem_size[1:0] == 2'b01) && dmem_addr[0]) ||
                       ((dmem_size[1:0] == 2'b10) && (dmem_addr[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_owner     <= 1'b0;
         r_req_valid <= 1'b0;
         r_addr      <= '0;
         r_wen       <= 1'b0;
         r_size      <= 3'b000;
         r_wdata     <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               // Data port wins: a WB stall freezes the whole pipe.
               if (dmem_en) begin
                  r_owner <= 1'b1;
                  r_addr  <= dmem_addr;
                  r_wen   <= dmem_wen;
                  r_size  <= dmem_size;
                  r_wdata <= dmem_wdata;
                  if (w_misalign) begin
                     r_state <= S_AERR;
                  end else begin
                     r_state     <= S_ISSUE;
                     r_req_valid <= 1'b1;
                  end
               end else if (imem_req) begin
                  r_owner     <= 1'b0;
                  r_addr      <= imem_addr;
                  r_wen       <= 1'b0;
                  r_size      <= 3'b010;
                  r_wdata     <= '0;
                  r_state     <= S_ISSUE;
                  r_req_valid <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (mem_req_ready) begin
                  r_req_valid <= 1'b0;
                  r_state     <= S_RESP;
               end
            end
            S_RESP: begin
               if (mem_resp_valid) r_state <= S_IDLE;
            end
            S_AERR: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_done   = (r_state == S_RESP) && mem_resp_valid;
   assign w_aerr   = (r_state == S_AERR);
   assign w_done_i = w_done && !r_owner;
   assign w_done_d = w_done && r_owner;

   // A port that dropped its request sees neither wait nor error.
   assign imem_wait     = imem_req && !w_done_i;
   assign imem_badmem_e = imem_req && w_done_i && mem_resp_err;
   assign imem_rdata    = mem_resp_data;

   assign dmem_wait     = dmem_en && !(w_done_d || w_aerr);
   assign dmem_badmem_e = dmem_en && ((w_done_d && mem_resp_err) || w_aerr);
   assign dmem_rdata    = mem_resp_data;

   assign mem_req_valid = r_req_valid;
   assign mem_req_addr  = r_addr;
   assign mem_req_wen   = r_wen;
   assign mem_req_size  = r_size;
   assign mem_req_wdata = r_wdata;

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// Bench for vscale_mem_arbiter: timeline model of grants, issue and completion cycles.
// Build with VSCALE_MEM_ARB_ALIGN_CHECK_EN defined to exercise local misalignment errors.
module tb_vscale_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_wait;
   logic        imem_badmem_e;
   logic        dmem_en;
   logic        dmem_wen;
   logic [2:0]  dmem_size;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_wait;
   logic        dmem_badmem_e;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_req_wen;
   logic [2:0]  mem_req_size;
   logic [31:0] mem_req_wdata;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        mem_resp_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vscale_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .imem_wait(imem_wait), .imem_badmem_e(imem_badmem_e),
      .dmem_en(dmem_en), .dmem_wen(dmem_wen), .dmem_size(dmem_size),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
      .dmem_wait(dmem_wait), .dmem_badmem_e(dmem_badmem_e),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
      .mem_req_size(mem_req_size), .mem_req_wdata(mem_req_wdata),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .mem_resp_err(mem_resp_err)
   );

   task automatic idle_inputs();
      imem_req       = 1'b0;
      imem_addr      = '0;
      dmem_en        = 1'b0;
      dmem_wen       = 1'b0;
      dmem_size      = 3'b000;
      dmem_addr      = '0;
      dmem_wdata     = '0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      mem_resp_err   = 1'b0;
   endtask

   // One or two transactions on a planned timeline. Data goes first when both request.
   // A transaction started at cycle s issues in s+1..s+1+rd and completes at s+2+rd+sd.
   task automatic run_scn(
      input bit          use_i, use_d,
      input logic [31:0] ia, da,
      input logic        dw,
      input logic [2:0]  dsz,
      input logic [31:0] dwd,
      input int          rdi, sdi, rdd, sdd,
      input logic [31:0] dat_i, dat_d,
      input logic        ei, ed,
      input int          drop_c,
      input bit          stray,
      input string       tag
   );
      int st_i, dn_i, st_d, dn_d, last;
      bit drop_i, drop_d;
      drop_i = use_i && !use_d && (drop_c >= 0);
      drop_d = use_d && !use_i && (drop_c >= 0);
      st_d = 0;
      dn_d = use_d ? 2 + rdd + sdd : -1;
      st_i = use_d ? dn_d + 1 : 0;
      dn_i = use_i ? st_i + 2 + rdi + sdi : -1;
      last = ((dn_i > dn_d) ? dn_i : dn_d) + 1;
      for (int c = 0; c <= last; c++) begin
         bit iq, dq, iss_i, iss_d, rsp_i, rsp_d, cmp_i, cmp_d;
         @(posedge clk);
         #1;
         iq = use_i && (c <= dn_i) && !(drop_i && c >= drop_c);
         dq = use_d && (c <= dn_d) && !(drop_d && c >= drop_c);
         iss_i = use_i && (c >= st_i + 1) && (c <= st_i + 1 + rdi);
         iss_d = use_d && (c >= st_d + 1) && (c <= st_d + 1 + rdd);
         rsp_i = use_i && (c >= st_i + 2 + rdi) && (c <= dn_i);
         rsp_d = use_d && (c >= st_d + 2 + rdd) && (c <= dn_d);
         imem_req   = iq;
         imem_addr  = ia;
         dmem_en    = dq;
         dmem_wen   = dw;
         dmem_size  = dsz;
         dmem_addr  = da;
         dmem_wdata = dwd;
         if (iss_i) mem_req_ready = (c == st_i + 1 + rdi);
         else if (iss_d) mem_req_ready = (c == st_d + 1 + rdd);
         else mem_req_ready = 1'($urandom % 2);
         mem_resp_data = $urandom;
         mem_resp_err  = 1'($urandom % 2);
         if (rsp_i || rsp_d) begin
            mem_resp_valid = (c == dn_i) || (c == dn_d);
            if (c == dn_i) begin
               mem_resp_data = dat_i;
               mem_resp_err  = ei;
            end
            if (c == dn_d) begin
               mem_resp_data = dat_d;
               mem_resp_err  = ed;
            end
         end else begin
            mem_resp_valid = stray ? 1'($urandom % 2) : 1'b0;
         end
         #3;
         cmp_i = iq && (c == dn_i);
         cmp_d = dq && (c == dn_d);
         checks++;
         if (mem_req_valid !== (iss_i || iss_d)) begin
            failures++;
            $display("FAIL %s req_valid c=%0d got=%b exp=%b", tag, c,
                     mem_req_valid, iss_i || iss_d);
         end
         if (iss_d) begin
            checks++;
            if ({mem_req_addr, mem_req_wen, mem_req_size, mem_req_wdata} !==
                {da, dw, dsz, dwd}) begin
               failures++;
               $display("FAIL %s dreq c=%0d got=%h/%b/%h/%h exp=%h/%b/%h/%h",
                        tag, c, mem_req_addr, mem_req_wen, mem_req_size,
                        mem_req_wdata, da, dw, dsz, dwd);
            end
         end
         if (iss_i) begin
            checks++;
            if ({mem_req_addr, mem_req_wen, mem_req_size} !== {ia, 1'b0, 3'b010}) begin
               failures++;
               $display("FAIL %s ireq c=%0d got=%h/%b/%h exp=%h/0/2", tag, c,
                        mem_req_addr, mem_req_wen, mem_req_size, ia);
            end
         end
         checks++;
         if (imem_wait !== (iq && !cmp_i)) begin
            failures++;
            $display("FAIL %s imem_wait c=%0d got=%b exp=%b", tag, c,
                     imem_wait, iq && !cmp_i);
         end
         checks++;
         if (dmem_wait !== (dq && !cmp_d)) begin
            failures++;
            $display("FAIL %s dmem_wait c=%0d got=%b exp=%b", tag, c,
                     dmem_wait, dq && !cmp_d);
         end
         checks++;
         if (imem_badmem_e !== (cmp_i && ei)) begin
            failures++;
            $display("FAIL %s imem_badmem c=%0d got=%b exp=%b", tag, c,
                     imem_badmem_e, cmp_i && ei);
         end
         checks++;
         if (dmem_badmem_e !== (cmp_d && ed)) begin
            failures++;
            $display("FAIL %s dmem_badmem c=%0d got=%b exp=%b", tag, c,
                     dmem_badmem_e, cmp_d && ed);
         end
         if (cmp_i) begin
            checks++;
            if (imem_rdata !== dat_i) begin
               failures++;
               $display("FAIL %s imem_rdata got=%h exp=%h", tag, imem_rdata, dat_i);
            end
         end
         if (cmp_d && !dw) begin
            checks++;
            if (dmem_rdata !== dat_d) begin
               failures++;
               $display("FAIL %s dmem_rdata got=%h exp=%h", tag, dmem_rdata, dat_d);
            end
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      imem_req = 1'b1;
      #3;
      checks++;
      if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_size, mem_req_wdata} !== '0) begin
         failures++;
         $display("FAIL reset_regs got=%b/%h/%b/%h/%h exp=0", mem_req_valid,
                  mem_req_addr, mem_req_wen, mem_req_size, mem_req_wdata);
      end
      checks++;
      if ({imem_wait, dmem_wait, imem_badmem_e, dmem_badmem_e} !== 4'b1000) begin
         failures++;
         $display("FAIL reset_outs got=%b exp=1000",
                  {imem_wait, dmem_wait, imem_badmem_e, dmem_badmem_e});
      end
      @(posedge clk);
      #1;
      imem_req = 1'b0;
      reset    = 1'b0;
   endtask

   task automatic test_fetch();
      run_scn(1, 0, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0,
              32'h00000013, 0, 0, 0, -1, 0, "fetch");
   endtask

   task automatic test_contention();
      run_scn(1, 1, 32'h400, 32'h1000, 1, 3'b010, 32'hDEADBEEF, 0, 0, 0, 0,
              32'h00000093, 32'h0, 0, 0, -1, 0, "contend");
   endtask

   task automatic test_ready_stall();
      run_scn(0, 1, 0, 32'h2004, 0, 3'b010, 32'h0, 0, 0, 3, 0,
              0, 32'h12345678, 0, 0, -1, 1, "stall");
   endtask

   task automatic test_load_err();
      run_scn(0, 1, 0, 32'h3000, 0, 3'b010, 32'h0, 0, 0, 0, 1,
              0, 32'h55AA55AA, 0, 1, -1, 0, "load_err");
   endtask

   task automatic test_drop();
      run_scn(1, 0, 32'h500, 0, 0, 0, 0, 0, 1, 0, 0,
              32'hBAD0BAD0, 0, 1, 0, 3, 0, "drop_resp");
      run_scn(1, 0, 32'h504, 0, 0, 0, 0, 0, 0, 0, 0,
              32'h00000033, 0, 0, 0, -1, 0, "after_drop");
      run_scn(0, 1, 0, 32'h600, 1, 3'b010, 32'hCAFEF00D, 0, 0, 1, 0,
              0, 0, 0, 1, 1, 0, "drop_store");
   endtask

   task automatic test_reset_mid();
      @(posedge clk);
      #1;
      imem_req  = 1'b1;
      imem_addr = 32'h300;
      #3;
      checks++;
      if (imem_wait !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid wait0 got=%b exp=1", imem_wait);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      #3;
      checks++;
      if (mem_req_valid !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid issue got=%b exp=1", mem_req_valid);
      end
      @(posedge clk);
      #1;
      reset          = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_err   = 1'b1;
      #3;
      checks++;
      if ({mem_req_valid, imem_wait, imem_badmem_e} !== 3'b010) begin
         failures++;
         $display("FAIL rst_mid idle got=%b exp=010",
                  {mem_req_valid, imem_wait, imem_badmem_e});
      end
      @(posedge clk);
      #1;
      mem_req_ready = 1'b1;
      #3;
      checks++;
      if ({mem_req_valid, mem_req_addr, imem_wait, imem_badmem_e} !== {1'b1, 32'h300, 2'b10}) begin
         failures++;
         $display("FAIL rst_mid reissue got=%b/%h/%b/%b exp=1/300/1/0",
                  mem_req_valid, mem_req_addr, imem_wait, imem_badmem_e);
      end
      @(posedge clk);
      #1;
      mem_req_ready = 1'b0;
      mem_resp_err  = 1'b0;
      mem_resp_data = 32'h0000CAFE;
      #3;
      checks++;
      if ({imem_wait, imem_badmem_e, imem_rdata} !== {2'b00, 32'h0000CAFE}) begin
         failures++;
         $display("FAIL rst_mid done got=%b/%b/%h exp=0/0/0000cafe",
                  imem_wait, imem_badmem_e, imem_rdata);
      end
      @(posedge clk);
      #1;
      idle_inputs();
      #3;
      checks++;
      if ({mem_req_valid, imem_wait} !== 2'b00) begin
         failures++;
         $display("FAIL rst_mid end got=%b exp=00", {mem_req_valid, imem_wait});
      end
   endtask

   task automatic test_align();
`ifdef VSCALE_MEM_ARB_ALIGN_CHECK_EN
      logic [31:0] addrs [2];
      logic [2:0]  sizes [2];
      addrs[0] = 32'h1002; sizes[0] = 3'b010;
      addrs[1] = 32'h1001; sizes[1] = 3'b001;
      for (int k = 0; k < 2; k++) begin
         for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            dmem_en       = (c < 2);
            dmem_wen      = 1'b0;
            dmem_size     = sizes[k];
            dmem_addr     = addrs[k];
            mem_req_ready = 1'b1;
            #3;
            checks++;
            if ({mem_req_valid, dmem_wait, dmem_badmem_e} !==
                {1'b0, c == 0, c == 1}) begin
               failures++;
               $display("FAIL align k=%0d c=%0d got=%b exp=0%b%b", k, c,
                        {mem_req_valid, dmem_wait, dmem_badmem_e}, c == 0, c == 1);
            end
         end
      end
      idle_inputs();
`else
      run_scn(0, 1, 0, 32'h1002, 0, 3'b010, 32'h0, 0, 0, 0, 0,
              0, 32'h0BADA11E, 0, 0, -1, 0, "misalign_issue");
`endif
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         int          mode, rdi, sdi, rdd, sdd, drop;
         logic [31:0] ia, da;
         logic [2:0]  sz;
         mode = $urandom_range(1, 3);
         rdi  = $urandom_range(0, 3);
         sdi  = $urandom_range(0, 3);
         rdd  = $urandom_range(0, 3);
         sdd  = $urandom_range(0, 3);
         ia   = $urandom & 32'hFFFF_FFFC;
         da   = $urandom;
         case ($urandom_range(0, 4))
            0: sz = 3'b000;
            1: sz = 3'b001;
            2: sz = 3'b010;
            3: sz = 3'b100;
            default: sz = 3'b101;
         endcase
         if (sz[1:0] == 2'b01) da[0] = 1'b0;
         if (sz[1:0] == 2'b10) da[1:0] = 2'b00;
         drop = -1;
         if (mode != 3 && ($urandom % 3 == 0)) begin
            drop = (mode == 1) ? $urandom_range(1, 2 + rdi + sdi)
                               : $urandom_range(1, 2 + rdd + sdd);
         end
         run_scn(mode[0], mode[1], ia, da, 1'($urandom % 2), sz, $urandom,
                 rdi, sdi, rdd, sdd, $urandom, $urandom,
                 1'($urandom % 2), 1'($urandom % 2), drop, 1, "random");
      end
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_fetch();
      test_contention();
      test_ready_stall();
      test_load_err();
      test_drop();
      test_reset_mid();
      test_align();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vscale_mem_arbiter.md
Name: vscale_mem_arbiter

Overview:
- Shares one single-ported memory request/response channel between the instruction fetch port (IF stage) and the data port (DX issue, WB completion) of the vscale pipeline.
- Arbitrates between the two ports, registers the granted request and sequences one transaction at a time.
- Returns read data and error status to the winner.
- Drives the per-port wait and badmem signals that the pipeline control uses for stall, kill and exception decisions.

Parameters:
- ADDR_WIDTH, 32, byte address width on all ports.
- DATA_WIDTH, 32, data width on all ports; fixed at 32 for RV32.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous active-high reset, sampled on rising clk
- imem_req  in  1  fetch request valid
- imem_addr  in  ADDR_WIDTH  fetch address
- imem_rdata  out  DATA_WIDTH  fetch data; valid when imem_req && !imem_wait
- imem_wait  out  1  fetch not complete this cycle
- imem_badmem_e  out  1  fetch completed with error; qualified like imem_rdata
- dmem_en  in  1  data access valid
- dmem_wen  in  1  1 = store, 0 = load
- dmem_size  in  3  funct3 size code, passed through
- dmem_addr  in  ADDR_WIDTH  data address
- dmem_wdata  in  DATA_WIDTH  store data
- dmem_rdata  out  DATA_WIDTH  load data; valid when dmem_en && !dmem_wait
- dmem_wait  out  1  data access not complete this cycle
- dmem_badmem_e  out  1  data access completed with error
- mem_req_valid  out  1  request valid to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_WIDTH  registered request address
- mem_req_wen  out  1  registered write enable
- mem_req_size  out  3  registered size
- mem_req_wdata  out  DATA_WIDTH  registered store data
- mem_resp_valid  in  1  response valid; memory never stalls responses
- mem_resp_data  in  DATA_WIDTH  read data
- mem_resp_err  in  1  bus error

Behaviour:
- States: IDLE, ISSUE, RESP. Register owner (0 = imem, 1 = dmem).
- Reset values:
  - state = IDLE; mem_req_valid = 0; request registers = 0.
  - All wait outputs follow the combinational rules below; badmem outputs = 0.
- IDLE:
  - If dmem_en, grant dmem. Otherwise, if imem_req, grant imem. Data port has fixed priority because WB stalls block the whole pipe.
  - On a grant: capture addr, wen, size and wdata (wen = 0 and size = 3'b010 for imem), set owner, go to ISSUE.
- ISSUE:
  - mem_req_valid = 1; request registers held stable.
  - mem_req_ready = 1 → go to RESP.
- RESP:
  - mem_resp_valid = 1 → go to IDLE.
  - Route mem_resp_data and mem_resp_err to the owner.
- Wait rules: a port's wait = its request asserted && !(state == RESP && owner == port && mem_resp_valid). The losing port stays waiting for the full duration.
- Minimum latency, zero-wait memory:
  - Cycle 0: request seen.
  - Cycle 1: ISSUE with ready.
  - Cycle 2: RESP with response; wait low and data valid.
  - Cycle 3: IDLE, next grant.
- badmem_e = mem_resp_err in the completion cycle only; otherwise 0.
- Requester drops its request while its transaction is in ISSUE or RESP (redirect or kill):
  - The transaction still completes; an accepted store is not retracted.
  - The response is discarded.
  - No wait or badmem is asserted to that port.
- mem_resp_valid outside RESP is ignored.
- Reset mid-transaction: return to IDLE next cycle; any later stray response is ignored.
- Request inputs must stay stable while the port's wait is high; changes are not tracked because the request was captured at grant.

Optional Feature:
- Macro: VSCALE_MEM_ARB_ALIGN_CHECK_EN.
- Defined:
  - A dmem grant whose address is misaligned is not issued. Misaligned means size halfword with addr[0] = 1, or size word with addr[1:0] != 0.
  - The arbiter goes to RESP-equivalent local completion the next cycle: dmem_wait = 0 and dmem_badmem_e = 1 for one cycle, then IDLE.
  - No mem_req_valid is asserted.
- Undefined: no alignment check; all grants issue to memory.

Test Plan:
- imem_req = 1, addr = 0x200, zero-wait memory returning 0x00000013 → imem_wait high for cycles 0–1, low in cycle 2 with imem_rdata = 0x00000013; mem_req_addr = 0x200, mem_req_wen = 0.
- imem_req and dmem_en (store, addr = 0x1000, wdata = 0xDEADBEEF) in the same cycle → store issued first with mem_req_wen = 1, then fetch; imem_wait held high until the fetch response (cycle 5).
- mem_req_ready held low for 3 cycles in ISSUE → mem_req_valid and the request registers stay stable; completion 3 cycles later.
- Load with mem_resp_err = 1 → dmem_badmem_e = 1 for exactly the completion cycle, dmem_wait = 0; next cycle dmem_badmem_e = 0.
- imem_req dropped while in RESP → response discarded; no imem_wait or imem_badmem_e; state returns to IDLE.
- reset asserted during ISSUE → IDLE and mem_req_valid = 0 next cycle; stray mem_resp_valid ignored. With VSCALE_MEM_ARB_ALIGN_CHECK_EN defined: word load at 0x1002 → no mem_req_valid, dmem_badmem_e = 1 in cycle 1.
